// File: rtl/fifo_rr_router_pkg.sv
// Shared FSM encoding, default word geometry and destination-field helper for the rr router.
package fifo_rr_router_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        SEND = 2'd3
    } rr_state_t;

    localparam int DEF_WORD_SIZE = 6;
    localparam int DEF_DEST_W    = 2;

    // Destination lives in the top DEST_W bits of a word.
    function automatic logic [DEF_DEST_W-1:0] word_dest(input logic [DEF_WORD_SIZE-1:0] w);
        return w[DEF_WORD_SIZE-1 -: DEF_DEST_W];
    endfunction

endpackage

// File: rtl/fifo_rr_router_rr_priority_pick.sv
// Round-robin pick: first eligible index at or above rr_ptr, wrapping at NUM_IN.
// Latency: purely combinational.
// Backpressure: none; the caller gates eligibility.
module rr_priority_pick
    import fifo_rr_router_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int GRANT_W = 2
) (
    input  logic [NUM_IN-1:0]  eligible,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic               found,
    output logic [GRANT_W-1:0] index
);

    int k;

    // Scan offsets from farthest to nearest so the nearest eligible index wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        k     = 0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            k = (int'(rr_ptr) + i) % NUM_IN;
            if (eligible[k]) begin
                found = 1'b1;
                index = GRANT_W'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_router.sv
// Round-robin mover from NUM_IN input FIFOs to 2**DEST_W output FIFOs; optional counters via FIFO_RR_ROUTER_STATS_EN.
// Latency: 4 cycles per word (ARB, POP, CAPT, SEND) when the target output is not almost_full.
// Backpressure: holds in SEND with out_push low while the target output reports almost_full.
module fifo_rr_router
    import fifo_rr_router_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int DEST_W    = DEF_DEST_W,
    parameter int GRANT_W   = 2
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       enable,
    input  logic [NUM_IN-1:0]          in_empty,
    input  logic [NUM_IN*WORD_SIZE-1:0] in_data,
    output logic [NUM_IN-1:0]          in_pop,
    input  logic [2**DEST_W-1:0]       out_almost_full,
    output logic [2**DEST_W-1:0]       out_push,
    output logic [WORD_SIZE-1:0]       out_data,
    output logic [GRANT_W-1:0]         grant,
    output logic                       idle,
    output logic [(2**DEST_W)*8-1:0]   words_sent
);

    localparam int NUM_OUT = 2**DEST_W;

    rr_state_t            state;
    logic [GRANT_W-1:0]   rr_ptr;
    logic [WORD_SIZE-1:0] hold_reg;
    logic [DEST_W-1:0]    dest_reg;
    logic [NUM_IN-1:0]    eligible;
    logic                 pick_found;
    logic [GRANT_W-1:0]   pick_idx;
    logic [WORD_SIZE-1:0] cur_word;
    logic [NUM_OUT-1:0]   dest_onehot;

    assign eligible = ~in_empty & {NUM_IN{enable}};
    assign cur_word = in_data[int'(grant)*WORD_SIZE +: WORD_SIZE];

    rr_priority_pick #(
        .NUM_IN  (NUM_IN),
        .GRANT_W (GRANT_W)
    ) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (pick_found),
        .index    (pick_idx)
    );

    // The push is the only combinational output: it reacts to almost_full in the same cycle.
    assign dest_onehot = NUM_OUT'(1) << dest_reg;
    assign out_push    = (state == SEND) ? (dest_onehot & ~out_almost_full) : '0;
    assign out_data    = hold_reg;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= ARB;
            rr_ptr   <= '0;
            grant    <= '0;
            hold_reg <= '0;
            dest_reg <= '0;
            in_pop   <= '0;
            idle     <= 1'b1;
        end else begin
            case (state)
                ARB: begin
                    if (pick_found) begin
                        grant  <= pick_idx;
                        rr_ptr <= (pick_idx == GRANT_W'(NUM_IN - 1)) ? '0 : pick_idx + GRANT_W'(1);
                        in_pop <= NUM_IN'(1) << pick_idx;
                        idle   <= 1'b0;
                        state  <= POP;
                    end
                end
                POP: begin
                    in_pop <= '0;
                    state  <= CAPT;
                end
                // FIFO read data is registered, so it is valid one cycle after the pop.
                CAPT: begin
                    hold_reg <= cur_word;
                    dest_reg <= cur_word[WORD_SIZE-1 -: DEST_W];
                    state    <= SEND;
                end
                SEND: begin
                    if (|out_push) begin
                        idle  <= 1'b1;
                        state <= ARB;
                    end
                end
                default: begin
                    in_pop <= '0;
                    idle   <= 1'b1;
                    state  <= ARB;
                end
            endcase
        end
    end

`ifdef FIFO_RR_ROUTER_STATS_EN
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_stats
        logic [7:0] cnt;
        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                cnt <= '0;
            end else if (out_push[k] && cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
        end
        assign words_sent[k*8 +: 8] = cnt;
    end
`else
    assign words_sent = '0;
`endif

`ifndef SYNTHESIS
    a_pop_onehot:  assert property (@(posedge clk) disable iff (!reset_L) $onehot0(in_pop));
    a_push_onehot: assert property (@(posedge clk) disable iff (!reset_L) $onehot0(out_push));
    a_no_pop_push: assert property (@(posedge clk) disable iff (!reset_L) !((|in_pop) && (|out_push)));
`endif

endmodule

// File: tb/tb_fifo_rr_router.sv
// Bench for fifo_rr_router: directed scenarios plus a random round-robin scoreboard run.
module tb_fifo_rr_router;
    import fifo_rr_router_pkg::*;

    localparam int NI = 4;
    localparam int WS = 6;
    localparam int DW = 2;
    localparam int NO = 4;
    localparam int GW = 2;

    logic             clk = 1'b0;
    logic             reset_L;
    logic             enable;
    logic [NI-1:0]    in_empty;
    logic [NI*WS-1:0] in_data;
    logic [NI-1:0]    in_pop;
    logic [NO-1:0]    out_almost_full;
    logic [NO-1:0]    out_push;
    logic [WS-1:0]    out_data;
    logic [GW-1:0]    grant;
    logic             idle;
    logic [NO*8-1:0]  words_sent;

    int compared   = 0;
    int mismatched = 0;

    logic [WS-1:0] q [NI][$];
    logic [WS-1:0] dout [NI];

    always #5 clk = ~clk;

    fifo_rr_router #(
        .NUM_IN    (NI),
        .WORD_SIZE (WS),
        .DEST_W    (DW),
        .GRANT_W   (GW)
    ) dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .enable          (enable),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .in_pop          (in_pop),
        .out_almost_full (out_almost_full),
        .out_push        (out_push),
        .out_data        (out_data),
        .grant           (grant),
        .idle            (idle),
        .words_sent      (words_sent)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < NI; i++) begin
            in_empty[i]         = (q[i].size() == 0);
            in_data[i*WS +: WS] = dout[i];
        end
    endtask

    // One clock: input FIFOs with registered read data react to the pop seen before the edge.
    task automatic tick();
        logic [NI-1:0] p;
        p = in_pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            if (p[i] && q[i].size() > 0) dout[i] = q[i].pop_front();
        drive_fifo();
        @(negedge clk);
    endtask

    task automatic wait_pop(input int limit, output logic [NI-1:0] p);
        int n;
        n = 0;
        while (in_pop == '0 && n < limit) begin
            tick();
            n++;
        end
        chk("pop_timeout", {31'd0, in_pop == '0}, 32'd0);
        p = in_pop;
    endtask

    task automatic do_reset();
        reset_L         = 1'b0;
        enable          = 1'b1;
        out_almost_full = '0;
        for (int i = 0; i < NI; i++) begin
            q[i].delete();
            dout[i] = '0;
        end
        drive_fifo();
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    function automatic logic [31:0] first_nonempty(input int ptr);
        for (int k = 0; k < NI; k++)
            if (q[(ptr + k) % NI].size() > 0) return 32'((ptr + k) % NI);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic [WS-1:0] w [NI];
        logic [NI-1:0] p;
        logic [WS-1:0] pend;
        logic [31:0]   j;
        logic [31:0]   exp_ws;
        logic [DW-1:0] d;
        bit            pend_v;
        int            model_ptr, sent, total, cyc, n;
        int            cnt [NO];

        // ---- reset values ----
        reset_L         = 1'b0;
        enable          = 1'b1;
        out_almost_full = '0;
        for (int i = 0; i < NI; i++) dout[i] = '0;
        drive_fifo();
        @(negedge clk);
        chk("rst_pop", 32'(in_pop), 32'd0);
        chk("rst_push", 32'(out_push), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_ws", words_sent, 32'd0);

        // ---- four inputs, one word each with dest = input index ----
        for (int i = 0; i < NI; i++) begin
            w[i] = {2'(i), 4'($urandom)};
            q[i].push_back(w[i]);
        end
        drive_fifo();
        @(negedge clk);
        reset_L = 1'b1;
        chk("seq_idle0", 32'(idle), 32'd1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk("seq_pop", 32'(in_pop), (c % 4 == 1) ? (32'd1 << ((c - 1) / 4)) : 32'd0);
            chk("seq_push", 32'(out_push), (c % 4 == 3) ? (32'd1 << ((c - 3) / 4)) : 32'd0);
            if (c % 4 == 3) chk("seq_data", 32'(out_data), 32'(w[(c - 3) / 4]));
            chk("seq_idle", 32'(idle), (c % 4 == 0) ? 32'd1 : 32'd0);
        end

        // ---- rr_ptr=2 with only inputs 0 and 3 pending: 3 goes first ----
        q[1].push_back(6'h05);
        drive_fifo();
        wait_pop(8, p);
        chk("rr_prep_pop", 32'(p), 32'b0010);
        repeat (3) tick();
        q[0].push_back(6'h11);
        q[3].push_back(6'h32);
        drive_fifo();
        wait_pop(8, p);
        chk("rr_first", 32'(p), 32'b1000);
        chk("rr_grant3", 32'(grant), 32'd3);
        repeat (3) tick();
        wait_pop(8, p);
        chk("rr_second", 32'(p), 32'b0001);
        repeat (3) tick();

        // ---- backpressure on output 2 for 10 cycles ----
        out_almost_full = 4'b0100;
        q[2].push_back(6'b10_0101);
        drive_fifo();
        wait_pop(8, p);
        chk("bp_pop", 32'(p), 32'b0100);
        repeat (2) tick();
        for (int c = 0; c < 10; c++) begin
            chk("bp_nopush", 32'(out_push), 32'd0);
            chk("bp_data", 32'(out_data), 32'h25);
            tick();
        end
        out_almost_full = '0;
        #1;
        chk("bp_push", 32'(out_push), 32'b0100);
        tick();
        chk("bp_after", 32'(out_push), 32'd0);
        chk("bp_idle", 32'(idle), 32'd1);

        // ---- enable low blocks arbitration ----
        enable = 1'b0;
        q[1].push_back(6'h0C);
        drive_fifo();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("en_nopop", 32'(in_pop), 32'd0);
            chk("en_idle", 32'(idle), 32'd1);
        end
        enable = 1'b1;
        tick();
        chk("en_pop", 32'(in_pop), 32'b0010);
        repeat (3) tick();

        // ---- reset while holding 0x2A in SEND ----
        out_almost_full = 4'b0100;
        q[0].push_back(6'h2A);
        drive_fifo();
        wait_pop(8, p);
        repeat (2) tick();
        chk("mid_data", 32'(out_data), 32'h2A);
        #2 reset_L = 1'b0;
        #1;
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_pop", 32'(in_pop), 32'd0);
        chk("mid_rst_push", 32'(out_push), 32'd0);
        @(negedge clk);
        out_almost_full = '0;
        reset_L = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("mid_nopush", 32'(out_push), 32'd0);
            chk("mid_idle", 32'(idle), 32'd1);
        end

        // ---- random traffic against a round-robin scoreboard ----
        do_reset();
        total = 40;
        for (int k = 0; k < NO; k++) cnt[k] = 0;
        for (int k = 0; k < total; k++) q[$urandom_range(0, NI - 1)].push_back(WS'($urandom));
        drive_fifo();
        model_ptr = 0;
        pend_v    = 1'b0;
        pend      = '0;
        sent      = 0;
        cyc       = 0;
        while (sent < total && cyc < 4000) begin
            enable = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NO; k++) out_almost_full[k] = ($urandom_range(0, 9) < 3);
            #1;
            chk("rnd_pop_push", {31'd0, (in_pop != '0) && (out_push != '0)}, 32'd0);
            if (out_push != '0) begin
                chk("rnd_push_pend", {31'd0, pend_v}, 32'd1);
                d = word_dest(pend);
                chk("rnd_push", 32'(out_push), 32'd1 << d);
                chk("rnd_data", 32'(out_data), 32'(pend));
                chk("rnd_af", {31'd0, out_almost_full[d]}, 32'd0);
                cnt[d]++;
                pend_v = 1'b0;
                sent++;
            end
            if (in_pop != '0) begin
                chk("rnd_pop_free", {31'd0, pend_v}, 32'd0);
                j = first_nonempty(model_ptr);
                chk("rnd_pop", 32'(in_pop), 32'd1 << j);
                chk("rnd_grant", 32'(grant), j);
                if (j < NI) begin
                    pend      = q[j][0];
                    pend_v    = 1'b1;
                    model_ptr = (int'(j) + 1) % NI;
                end
            end
            tick();
            cyc++;
        end
        chk("rnd_sent", 32'(sent), 32'(total));
        out_almost_full = '0;
        enable = 1'b1;
        tick();
`ifdef FIFO_RR_ROUTER_STATS_EN
        exp_ws = {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])};
`else
        exp_ws = 32'd0;
`endif
        chk("rnd_ws", words_sent, exp_ws);

        // ---- 300 words to output 1: counter saturates ----
        do_reset();
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 75; k++) q[i].push_back({2'b01, 4'($urandom)});
        drive_fifo();
        n = 0;
        while (!(q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0 && idle) && n < 2000) begin
            tick();
            n++;
        end
        chk("sat_timeout", {31'd0, n >= 2000}, 32'd0);
        tick();
`ifdef FIFO_RR_ROUTER_STATS_EN
        exp_ws = 32'h0000_FF00;
`else
        exp_ws = 32'd0;
`endif
        chk("sat_ws", words_sent, exp_ws);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
